// File: rtl/mic_peak_sampler_pkg.sv
// Shared frame constants, ADC FSM states and word helpers for the
// Pmod MIC3 peak sampler.
package mic_peak_sampler_pkg;

   localparam int MIC_BITS       = 12;
   localparam int MIC_FRAME_BITS = 16;
   localparam int MIC_LEAD_ZEROS = MIC_FRAME_BITS - MIC_BITS;
   localparam int MIC_HALVES     = 2 * MIC_FRAME_BITS;

   typedef logic [MIC_BITS-1:0] mic_word_t;

   typedef enum logic [1:0] {
      ADC_IDLE  = 2'd0,
      ADC_SHIFT = 2'd1,
      ADC_DONE  = 2'd2
   } adc_state_e;

   function automatic mic_word_t mic_max(
      input mic_word_t a,
      input mic_word_t b
   );
      return (a > b) ? a : b;
   endfunction

   function automatic mic_word_t mic_sat_sub(
      input mic_word_t a,
      input mic_word_t b
   );
      return (a > b) ? mic_word_t'(a - b) : '0;
   endfunction

endpackage

// File: rtl/mic_peak_sampler_spi_adc_rx.sv
// ADCS7476 serial receiver: SCLK divider, chip select, frame shifter
// and the IDLE/SHIFT/DONE sequencer.
module spi_adc_rx
   import mic_peak_sampler_pkg::*;
#(
   parameter int CLK_DIV = 25
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic            miso,
   output logic            busy,
   output logic            done,
   output logic            sclk,
   output logic            cs_n,
   output logic [MIC_BITS-1:0] data
);

   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int HALF_W = $clog2(MIC_HALVES + 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(MIC_HALVES);

   adc_state_e            state_q, state_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [HALF_W-1:0]     half_q, half_d;
   logic                  sclk_q, sclk_d;
   logic [MIC_BITS-1:0]   shift_q, shift_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ADC_IDLE;
         div_q   <= '0;
         half_q  <= '0;
         sclk_q  <= 1'b1;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         half_q  <= half_d;
         sclk_q  <= sclk_d;
         shift_q <= shift_d;
      end
   end

   // Half 0 is a chip-select lead-in with SCLK still high; odd halves
   // are SCLK low, even halves high, and each rise captures one bit.
   // Only the last 12 bits survive the shifter, dropping the lead zeros.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      half_d  = half_q;
      sclk_d  = sclk_q;
      shift_d = shift_q;
      unique case (state_q)
         ADC_IDLE: begin
            sclk_d = 1'b1;
            if (start) begin
               state_d = ADC_SHIFT;
               div_d   = '0;
               half_d  = '0;
            end
         end
         ADC_SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d  = '0;
               half_d = half_q + 1'b1;
               if (half_d[0]) begin
                  sclk_d = 1'b0;
               end else begin
                  sclk_d  = 1'b1;
                  shift_d = {shift_q[MIC_BITS-2:0], miso};
                  if (half_d == HALF_LAST) begin
                     state_d = ADC_DONE;
                  end
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         ADC_DONE: begin
            sclk_d  = 1'b1;
            state_d = ADC_IDLE;
         end
         default: begin
            state_d = ADC_IDLE;
         end
      endcase
   end

   assign busy = (state_q != ADC_IDLE);
   assign done = (state_q == ADC_DONE);
   assign cs_n = (state_q != ADC_SHIFT);
   assign sclk = sclk_q;
   assign data = shift_q;

endmodule

// File: rtl/mic_peak_sampler.sv
// Pmod MIC3 sampler: fixed-rate ADC reads and a windowed peak hold for
// the renderers. Define MIC_PEAK_DECAY_EN for a gradually falling bar.
module mic_peak_sampler
   import mic_peak_sampler_pkg::*;
#(
   parameter int CLK_DIV     = 25,
   parameter int SAMPLE_DIV  = 5000,
   parameter int PEAK_WINDOW = 4000,
   parameter int DECAY_STEP  = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                mic_miso,
   output logic                mic_sclk,
   output logic                mic_cs_n,
   output logic [MIC_BITS-1:0] sample,
   output logic                sample_valid,
   output logic [MIC_BITS-1:0] mic_data,
   output logic                peak_valid
);

   localparam int TIM_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int WIN_W = (PEAK_WINDOW > 1) ? $clog2(PEAK_WINDOW) : 1;
   localparam logic [TIM_W-1:0] TIM_LAST = TIM_W'(SAMPLE_DIV - 1);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(PEAK_WINDOW - 1);

   logic [TIM_W-1:0] timer_q, timer_d;
   logic [WIN_W-1:0] win_q, win_d;
   mic_word_t        sample_q, sample_d;
   logic             sample_valid_q, sample_valid_d;
   mic_word_t        peak_q, peak_d;
   mic_word_t        mic_data_q, mic_data_d;
   logic             peak_valid_q, peak_valid_d;
   mic_word_t        win_peak;

   logic             adc_start;
   logic             adc_busy;
   logic             adc_done;
   mic_word_t        adc_data;

`ifdef MIC_PEAK_DECAY_EN
   localparam mic_word_t DECAY = mic_word_t'(DECAY_STEP);
`else
   logic unused_decay;
   assign unused_decay = ^DECAY_STEP;
`endif

   spi_adc_rx #(
      .CLK_DIV (CLK_DIV)
   ) u_adc (
      .clock (clock),
      .reset (reset),
      .start (adc_start),
      .miso  (mic_miso),
      .busy  (adc_busy),
      .done  (adc_done),
      .sclk  (mic_sclk),
      .cs_n  (mic_cs_n),
      .data  (adc_data)
   );

   // A start that lands on a busy receiver is simply lost.
   assign adc_start = (timer_q == TIM_LAST) && !adc_busy;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         timer_q        <= '0;
         win_q          <= '0;
         sample_q       <= '0;
         sample_valid_q <= 1'b0;
         peak_q         <= '0;
         mic_data_q     <= '0;
         peak_valid_q   <= 1'b0;
      end else begin
         timer_q        <= timer_d;
         win_q          <= win_d;
         sample_q       <= sample_d;
         sample_valid_q <= sample_valid_d;
         peak_q         <= peak_d;
         mic_data_q     <= mic_data_d;
         peak_valid_q   <= peak_valid_d;
      end
   end

   always_comb begin
      timer_d        = (timer_q == TIM_LAST) ? '0 : timer_q + 1'b1;
      sample_d       = adc_done ? adc_data : sample_q;
      sample_valid_d = adc_done;
      win_d          = win_q;
      peak_d         = peak_q;
      mic_data_d     = mic_data_q;
      peak_valid_d   = 1'b0;
      win_peak       = mic_max(peak_q, sample_q);
      // The sample closing a window still counts toward that window.
      if (sample_valid_q) begin
         if (win_q == WIN_LAST) begin
`ifdef MIC_PEAK_DECAY_EN
            mic_data_d = mic_max(win_peak,
                                 mic_sat_sub(mic_data_q, DECAY));
`else
            mic_data_d = win_peak;
`endif
            peak_d       = '0;
            win_d        = '0;
            peak_valid_d = 1'b1;
         end else begin
            peak_d = win_peak;
            win_d  = win_q + 1'b1;
         end
      end
   end

   assign sample       = sample_q;
   assign sample_valid = sample_valid_q;
   assign mic_data     = mic_data_q;
   assign peak_valid   = peak_valid_q;

endmodule
